led_test_sel: RTL and testbench
===============================

Name: led_test_sel

Overview:
- Registered 2-to-1 LED source selector.
- Two level inputs (a, b) and one active-low push-button (key_in) drive one LED output (led_out).
- The button is synchronised and debounced; its debounced level chooses which input reaches the LED.
- Sits at the board top level, between raw pins and the LED pad.

Parameters:
- DEBOUNCE_CYCLES, default 1000000, clk cycles key level must hold stable before being accepted (20 ms at 50 MHz); legal range 1..2^24-1.
- SYNC_STAGES, default 2, flip-flop stages in each input synchroniser; legal 2..4.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- a  input  1  data source driven to LED while button pressed
- b  input  1  data source driven to LED while button released
- key_in  input  1  raw push-button, active-low (0 = pressed), asynchronous, may bounce
- led_out  output  1  registered LED drive, 1 = LED on

Behaviour:
- One clock; reset is synchronous and active-high, sampled on rising clk.
- While rst=1 at an edge:
  - all synchroniser flops cleared to 0, except the key chain, which presets to 1 (released);
  - debounce counter = 0; debounced key (key_db) = 1; led_out = 0.
- Synchronisers: a, b and key_in each pass through SYNC_STAGES flops, giving a_s, b_s, key_s.
- Debounce:
  - when key_s != key_db, counter increments each cycle;
  - when key_s == key_db, counter clears to 0;
  - when counter reaches DEBOUNCE_CYCLES-1 while key_s still differs, key_db <= key_s and counter <= 0 on the same edge;
  - any bounce back to key_db before that clears the counter; no partial credit.
- Select, registered: led_out <= (key_db == 0) ? a_s : b_s.
- Truth table (key_db, a, b -> led_out):
  - 0,0,x -> 0
  - 0,1,x -> 1
  - 1,x,0 -> 0
  - 1,x,1 -> 1
- Latency:
  - a or b change to led_out: SYNC_STAGES+1 cycles (3 at default), provided key_db is stable.
  - key_in change to led_out: SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
- Simultaneous key and data change: each path obeys its own latency; no glitch filtering on a/b.
- Reset mid-debounce: counter is discarded; key_db returns to released (1).
- First led_out value after reset release reflects b.

Decomposition:
- Shared package led_pkg:
  - KEY_PRESSED = 1'b0, KEY_RELEASED = 1'b1, LED_ON = 1'b1;
  - counter width function clog2(DEBOUNCE_CYCLES).
- One natural sub-module, key_debounce (ports clk, rst, key_raw, key_db), containing the key synchroniser and counter.
- a/b synchronisers and the output mux live in led_test_sel.

Test Plan:
- Reset: rst=1 for 3 cycles with a=1, b=1, key_in=0 -> led_out=0 during reset; key_db=1; first output after release is 1 (=b).
- Released path (DEBOUNCE_CYCLES=4): key_in=1, sweep (a,b) through 00, 01, 10, 11, 5 cycles each -> led_out = 0, 1, 0, 1, each 3 cycles after the change.
- Pressed path: key_in=0 held 10 cycles, then the same (a,b) sweep -> led_out = 0, 0, 1, 1.
- Bounce rejection: key_in toggles 1->0->1 every 2 cycles for 12 cycles with a=1, b=0 -> led_out stays 0.
- Key acceptance: key_in=0 held stable with a=1, b=0 -> led_out rises exactly SYNC_STAGES+4+1 = 7 cycles after the key edge.
- Reset mid-debounce: key_in=0 for 2 cycles, then rst=1 for 1 cycle -> counter cleared; after release a full 4 stable cycles are needed again before led_out follows a.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants and elaboration helpers for the LED source selector.
// Key polarity is active-low at the pin; the LED is active-high.
package led_pkg;

  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;
  localparam logic LED_ON       = 1'b1;

  function automatic int clog2(input longint unsigned v);
    int r;
    r = 0;
    while ((64'd1 << r) < v) r++;
    return r;
  endfunction

  // A one-cycle debounce still needs a one-bit counter to compare against.
  function automatic int cnt_width(input longint unsigned cycles);
    return (clog2(cycles) < 1) ? 1 : clog2(cycles);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button synchroniser and stability counter.
// The key level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
module key_debounce
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_db
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] key_sync;
  logic                   key_s;
  logic [CNT_W-1:0]       cnt;

  assign key_s = key_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      // Presetting the chain to released keeps a held button from being seen at reset exit.
      key_sync <= {SYNC_STAGES{KEY_RELEASED}};
      cnt      <= '0;
      key_db   <= KEY_RELEASED;
    end else begin
      key_sync <= {key_sync[SYNC_STAGES-2:0], key_raw};
      if (key_s != key_db) begin
        if (cnt == CNT_LAST) begin
          key_db <= key_s;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        // Any return to the accepted level forfeits all accumulated count.
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/led_test_sel.sv
// Registered 2-to-1 LED source selector: debounced button picks a (pressed) or b (released).
// Data inputs are synchronised but not filtered.
module led_test_sel
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic key_in,
  output logic led_out
);

  logic [SYNC_STAGES-1:0] a_sync;
  logic [SYNC_STAGES-1:0] b_sync;
  logic                   a_s;
  logic                   b_s;
  logic                   key_db;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_key_debounce (
    .clk    (clk),
    .rst    (rst),
    .key_raw(key_in),
    .key_db (key_db)
  );

  assign a_s = a_sync[SYNC_STAGES-1];
  assign b_s = b_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sync  <= '0;
      b_sync  <= '0;
      led_out <= ~LED_ON;
    end else begin
      a_sync  <= {a_sync[SYNC_STAGES-2:0], a};
      b_sync  <= {b_sync[SYNC_STAGES-2:0], b};
      // Output register stage: one cycle after the synchronisers.
      led_out <= (key_db == KEY_PRESSED) ? a_s : b_s;
    end
  end

endmodule

// File: tb/tb_led_test_sel.sv
// Scoreboard bench for led_test_sel with a short debounce window.
module tb_led_test_sel;

  localparam int DEB     = 4;
  localparam int SYNC    = 2;
  localparam int LAT_DAT = SYNC + 1;
  localparam int LAT_KEY = SYNC + DEB + 1;

  logic clk = 1'b0;
  logic rst, a, b, key_in, led_out;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int    due;
    logic  val;
    string tag;
  } exp_t;

  exp_t sb[$];
  logic kdb_exp;

  led_test_sel #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .key_in (key_in),
    .led_out(led_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input int due, input logic val, input string tag);
    exp_t e;
    e.due = due;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold inputs for 'hold' cycles; a key change takes effect LAT_KEY cycles later.
  task automatic phase(input logic av, input logic bv, input logic kv, input int hold,
                       input string tag);
    int   n0;
    logic kd;
    n0 = cyc;
    a = av;
    b = bv;
    key_in = kv;
    for (int d = n0 + LAT_DAT; d <= n0 + hold + LAT_DAT - 1; d++) begin
      kd = (kv != kdb_exp && d >= n0 + LAT_KEY) ? kv : kdb_exp;
      push(d, (kd == 1'b0) ? av : bv, tag);
    end
    kdb_exp = kv;
    repeat (hold) tick();
  endtask

  // Short key pulse that must not be accepted.
  task automatic bounce(input logic kv, input int len);
    int n0;
    n0 = cyc;
    key_in = kv;
    for (int d = n0 + LAT_DAT; d <= n0 + len + LAT_DAT - 1; d++)
      push(d, (kdb_exp == 1'b0) ? a : b, "bounce");
    repeat (len) tick();
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk(e.tag, led_out, e.val);
    end
  end

  initial begin
    rst = 1'b1;
    a = 1'b1;
    b = 1'b1;
    key_in = 1'b0;
    kdb_exp = 1'b1;
    for (int d = 1; d <= 3; d++) push(d, 1'b0, "rst_led");
    repeat (3) tick();
    chk("rst_key_db", dut.u_key_debounce.key_db, 1);

    // Release reset; synchronisers start cleared, so b shows up after the data latency.
    rst = 1'b0;
    key_in = 1'b1;
    push(cyc + 1, 1'b0, "rst_fill");
    push(cyc + 2, 1'b0, "rst_fill");
    phase(1'b1, 1'b1, 1'b1, 3, "rst_first_b");

    phase(1'b0, 1'b0, 1'b1, 5, "rel_00");
    phase(1'b0, 1'b1, 1'b1, 5, "rel_01");
    phase(1'b1, 1'b0, 1'b1, 5, "rel_10");
    phase(1'b1, 1'b1, 1'b1, 5, "rel_11");

    phase(1'b1, 1'b1, 1'b0, 10, "press_hold");
    chk("press_key_db", dut.u_key_debounce.key_db, 0);
    phase(1'b0, 1'b0, 1'b0, 5, "prs_00");
    phase(1'b0, 1'b1, 1'b0, 5, "prs_01");
    phase(1'b1, 1'b0, 1'b0, 5, "prs_10");
    phase(1'b1, 1'b1, 1'b0, 5, "prs_11");

    phase(1'b1, 1'b0, 1'b1, 10, "release");

    for (int i = 0; i < 3; i++) begin
      bounce(1'b0, 2);
      bounce(1'b1, 2);
    end
    bounce(1'b0, DEB - 1);
    bounce(1'b1, 3);
    chk("bounce_key_db", dut.u_key_debounce.key_db, 1);

    phase(1'b1, 1'b0, 1'b0, 10, "key_accept");
    phase(1'b1, 1'b0, 1'b1, 10, "release2");

    // Reset two cycles into a press: the count must restart from zero.
    key_in = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    push(cyc + 1, 1'b0, "mid_rst");
    tick();
    rst = 1'b0;
    kdb_exp = 1'b1;
    push(cyc + 1, 1'b0, "mid_rst_fill");
    push(cyc + 2, 1'b0, "mid_rst_fill");
    phase(1'b1, 1'b0, 1'b0, 10, "mid_rst_key");

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) chk("drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
